// File: rtl/mvm_pkg.sv
// Shared types and constants for the matrix-vector unit and its stream transmitter.
package mvm_pkg;

    localparam int SIZE      = 4;
    localparam int FRAME_LEN = SIZE * SIZE + 2 * SIZE;

    typedef logic signed [7:0]  mvm_in_t;
    typedef logic signed [15:0] mvm_out_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        FINISH
    } tx_state_t;

endpackage

// File: rtl/mvm_tx_mem.sv
// Word storage for the stream transmitter: synchronous write, combinational read.
module mvm_tx_mem
    import mvm_pkg::*;
#(
    parameter int DEPTH = 120,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  mvm_in_t       wdata,
    input  logic [AW-1:0] raddr,
    output mvm_in_t       rdata
);

    mvm_in_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Out-of-range pointers only occur while the stream is not presenting data.
    assign rdata = (32'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/mvm_stream_tx.sv
// Streams preloaded matrix/vector/bias frames to the mvm datapath over valid/ready.
module mvm_stream_tx
    import mvm_pkg::*;
#(
    parameter int SIZE       = 4,
    parameter int MAX_FRAMES = 5
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              wr_en,
    input  logic [$clog2(MAX_FRAMES*(SIZE*SIZE+2*SIZE))-1:0] wr_addr,
    input  logic signed [7:0]                 wr_data,
    input  logic                              start,
    input  logic [$clog2(MAX_FRAMES+1)-1:0]   num_frames,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic signed [7:0]                 m_data,
    output logic                              m_last,
    output logic                              busy,
    output logic                              done
);

    localparam int FRAME_LEN = SIZE * SIZE + 2 * SIZE;
    localparam int DEPTH     = MAX_FRAMES * FRAME_LEN;
    localparam int AW        = $clog2(DEPTH);
    localparam int FW        = $clog2(MAX_FRAMES + 1);
    localparam int WW        = $clog2(FRAME_LEN);

    localparam logic [FW-1:0] MAX_F  = FW'(MAX_FRAMES);
    localparam logic [WW-1:0] LAST_W = WW'(FRAME_LEN - 1);

    tx_state_t     state, state_next;
    logic [AW-1:0] rd_ptr, rd_next;
    logic [WW-1:0] word_in_frame, wif_next;
    logic [FW-1:0] frames_left, fl_next;
    logic          mem_we;
    mvm_in_t       rd_data;

    // Stored data is frozen while a transfer is in flight so the stream stays stable.
    assign mem_we = wr_en && !reset && (state == IDLE) && (32'(wr_addr) < DEPTH);

    mvm_tx_mem #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(wr_addr),
        .wdata(wr_data),
        .raddr(rd_ptr),
        .rdata(rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rd_ptr        <= '0;
            word_in_frame <= '0;
            frames_left   <= '0;
        end else begin
            state         <= state_next;
            rd_ptr        <= rd_next;
            word_in_frame <= wif_next;
            frames_left   <= fl_next;
        end
    end

    always_comb begin
        state_next = state;
        rd_next    = rd_ptr;
        wif_next   = word_in_frame;
        fl_next    = frames_left;
        m_valid    = 1'b0;
        m_data     = '0;
        m_last     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (num_frames == '0) begin
                        state_next = FINISH;
                    end else begin
                        state_next = SEND;
                        rd_next    = '0;
                        wif_next   = '0;
                        fl_next    = (num_frames > MAX_F) ? MAX_F : num_frames;
                    end
                end
            end
            SEND: begin
                m_valid = 1'b1;
                busy    = 1'b1;
                m_data  = rd_data;
                m_last  = (word_in_frame == LAST_W);
                if (m_ready) begin
                    rd_next = rd_ptr + 1'b1;
                    if (word_in_frame == LAST_W) begin
                        wif_next = '0;
                        fl_next  = frames_left - 1'b1;
                        if (frames_left == FW'(1)) begin
                            state_next = FINISH;
                        end
                    end else begin
                        wif_next = word_in_frame + 1'b1;
                    end
                end
            end
            FINISH: begin
                done       = 1'b1;
                rd_next    = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mvm_stream_tx.sv
// Self-checking bench for mvm_stream_tx: table of send scenarios plus reset/busy corner cases.
module tb_mvm_stream_tx;

    localparam int FLEN  = 24;
    localparam int MAXF  = 5;
    localparam int DEPTH = 120;

    logic              clk;
    logic              reset;
    logic              wr_en;
    logic [6:0]        wr_addr;
    logic signed [7:0] wr_data;
    logic              start;
    logic [2:0]        num_frames;
    logic              m_valid;
    logic              m_ready;
    logic signed [7:0] m_data;
    logic              m_last;
    logic              busy;
    logic              done;

    int total = 0;
    int bad   = 0;

    logic [7:0] ref_mem [DEPTH];

    typedef struct {
        int nreq;
        int ready_pct;
        bit disturb;
        bit wr_with_start;
        int exp_words;
        int exp_lasts;
    } vec_t;

    vec_t vecs [8];

    mvm_stream_tx dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .num_frames(num_frames),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkQuiet(input string tag, input bit exp_done);
        checkOutput({tag, "_valid"}, 32'(m_valid), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_done"}, 32'(done), 32'(exp_done));
        checkOutput({tag, "_data"}, {24'b0, m_data}, 0);
        checkOutput({tag, "_last"}, 32'(m_last), 0);
    endtask

    // Idle write; the model only stores addresses that exist.
    task automatic writeWord(input logic [6:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        m_ready = 1'($urandom_range(1));
        @(posedge clk);
        if (int'(a) < DEPTH) ref_mem[a] = d;
        #1 wr_en = 1'b0;
        @(negedge clk);
        checkOutput("idle_valid", 32'(m_valid), 0);
    endtask

    task automatic runFrames(input int nreq, input int ready_pct, input bit disturb,
                             input bit wr_with_start, input logic [6:0] wa, input logic [7:0] wd,
                             input int exp_words, input int exp_lasts, input int abort_after);
        logic [7:0] q[$];
        int nclamp, sent, cycles, obs_hs, obs_last;
        bit rdy;
        start      = 1'b1;
        num_frames = 3'(nreq);
        if (wr_with_start) begin
            wr_en   = 1'b1;
            wr_addr = wa;
            wr_data = wd;
        end
        @(posedge clk);
        if (wr_with_start && int'(wa) < DEPTH) ref_mem[wa] = wd;
        nclamp = (nreq > MAXF) ? MAXF : nreq;
        for (int i = 0; i < nclamp * FLEN; i++) q.push_back(ref_mem[i]);
        #1 start = 1'b0;
        wr_en  = 1'b0;
        sent = 0; cycles = 0; obs_hs = 0; obs_last = 0;
        while (sent < q.size() && cycles < 4000) begin
            rdy     = ($urandom_range(99) < 32'(ready_pct));
            m_ready = rdy;
            if (disturb && cycles == 5) begin
                start      = 1'b1;
                num_frames = 3'd5;
                wr_en      = 1'b1;
                wr_addr    = 7'd3;
                wr_data    = ~ref_mem[3];
            end
            @(negedge clk);
            checkOutput("valid", 32'(m_valid), 1);
            checkOutput("busy", 32'(busy), 1);
            checkOutput("done", 32'(done), 0);
            checkOutput("data", {24'b0, m_data}, {24'b0, q[sent]});
            checkOutput("last", 32'(m_last), 32'((sent % FLEN) == FLEN - 1));
            if (m_valid && m_ready) begin
                obs_hs++;
                if (m_last) obs_last++;
            end
            @(posedge clk);
            if (rdy) sent++;
            #1 start = 1'b0;
            wr_en  = 1'b0;
            cycles++;
            if (abort_after > 0 && sent == abort_after) return;
        end
        checkOutput("handshakes", 32'(obs_hs), 32'(exp_words));
        checkOutput("last_count", 32'(obs_last), 32'(exp_lasts));
        m_ready = 1'($urandom_range(1));
        @(negedge clk);
        checkQuiet("fin", 1'b1);
        @(posedge clk);
        #1 m_ready = 1'($urandom_range(1));
        @(negedge clk);
        checkQuiet("post", 1'b0);
    endtask

    task automatic applyStimulus(input vec_t v);
        runFrames(v.nreq, v.ready_pct, v.disturb, v.wr_with_start, 7'd0, 8'hA5,
                  v.exp_words, v.exp_lasts, 0);
    endtask

    initial begin
        vecs[0] = '{nreq: 1, ready_pct: 100, disturb: 0, wr_with_start: 0, exp_words: 24,  exp_lasts: 1};
        vecs[1] = '{nreq: 5, ready_pct: 50,  disturb: 0, wr_with_start: 0, exp_words: 120, exp_lasts: 5};
        vecs[2] = '{nreq: 0, ready_pct: 100, disturb: 0, wr_with_start: 0, exp_words: 0,   exp_lasts: 0};
        vecs[3] = '{nreq: 7, ready_pct: 100, disturb: 0, wr_with_start: 0, exp_words: 120, exp_lasts: 5};
        vecs[4] = '{nreq: 1, ready_pct: 100, disturb: 1, wr_with_start: 0, exp_words: 24,  exp_lasts: 1};
        vecs[5] = '{nreq: 1, ready_pct: 100, disturb: 0, wr_with_start: 0, exp_words: 24,  exp_lasts: 1};
        vecs[6] = '{nreq: 2, ready_pct: 60,  disturb: 0, wr_with_start: 1, exp_words: 48,  exp_lasts: 2};
        vecs[7] = '{nreq: 3, ready_pct: 30,  disturb: 0, wr_with_start: 0, exp_words: 72,  exp_lasts: 3};

        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; num_frames = '0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkQuiet("reset", 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            writeWord(7'(i), (i < FLEN) ? 8'(i + 1) : 8'($urandom_range(255)));
        end
        writeWord(7'd120, 8'h11);
        writeWord(7'd127, 8'h22);

        for (int i = 0; i < 8; i++) begin
            $display("[TB] scenario %0d: num_frames=%0d ready=%0d%%", i, vecs[i].nreq, vecs[i].ready_pct);
            applyStimulus(vecs[i]);
        end

        // Reset mid-stream, with a competing start and write that must both lose.
        runFrames(2, 100, 1'b0, 1'b0, 7'd0, 8'h00, 0, 0, 10);
        reset      = 1'b1;
        start      = 1'b1;
        num_frames = 3'd1;
        wr_en      = 1'b1;
        wr_addr    = 7'd5;
        wr_data    = ~ref_mem[5];
        @(posedge clk);
        #1 reset = 1'b0;
        start = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        checkQuiet("abort", 1'b0);
        @(negedge clk);
        checkQuiet("abort2", 1'b0);

        runFrames(1, 100, 1'b0, 1'b0, 7'd0, 8'h00, 24, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
